// File: rtl/water_led.sv
// water_led: eight-LED active-low running light advanced by a free-running prescaler
module water_led #(
  parameter logic [26:0] CNT_MAX = 27'd24_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  output logic [7:0] led_out
);
  logic [26:0] cnt;
  logic        step;
  logic [7:0]  lit;
  logic        one_cold;
  // step fires on the terminal count; one_cold guards against a corrupted pattern
  always_comb begin
    step = cnt == CNT_MAX;
    lit = ~led_out;
    one_cold = (lit != 8'd0) && ((lit & (lit - 8'd1)) == 8'd0);
  end
  // prescaler wraps to zero at the terminal count
  always_ff @(posedge sys_clk)
    cnt <= (!sys_rst_n || step) ? 27'd0 : cnt + 27'd1;
  // rotate the single dark-driving zero toward the MSB, recovering to LED0 if not one-cold
  always_ff @(posedge sys_clk)
    led_out <= !sys_rst_n ? 8'hFE : !step ? led_out : one_cold ? {led_out[6:0], led_out[7]} : 8'hFE;
endmodule

// File: tb/tb_water_led.sv
// tb_water_led: scoreboard bench for water_led at CNT_MAX=24 and CNT_MAX=0
module tb_water_led;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] led_a;
  logic [7:0] led_b;
  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 sys_clk = ~sys_clk;

  water_led #(.CNT_MAX(27'd24)) u_dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .led_out(led_a));
  water_led #(.CNT_MAX(27'd0))  u_fast (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .led_out(led_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rot(input int n);
    logic [7:0] v;
    v = 8'hFE;
    repeat (n % 8) v = {v[6:0], v[7]};
    return v;
  endfunction

  // one clock edge: push expectations for the edge, then pop and compare after it
  task automatic cycle();
    logic [7:0] ea, eb;
    k = sys_rst_n ? k + 1 : 0;
    q_a.push_back(rot(k / 25));
    q_b.push_back(rot(k));
    @(posedge sys_clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    chk(sys_rst_n ? "led_24" : "rst_led_24", {24'd0, led_a}, {24'd0, ea});
    chk(sys_rst_n ? "led_0" : "rst_led_0", {24'd0, led_b}, {24'd0, eb});
    chk("one_cold_24", $countones(~led_a), 1);
    chk("one_cold_0", $countones(~led_b), 1);
    if (!sys_rst_n) chk("rst_cnt", {5'd0, u_dut.cnt}, 32'd0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    repeat (2) cycle();
    sys_rst_n = 1'b1;
    repeat (610) cycle();
    sys_rst_n = 1'b0;
    cycle();
    sys_rst_n = 1'b1;
    repeat (110) cycle();
    chk("pre_rst_led", {24'd0, led_a}, 32'h000000EF);
    chk("pre_rst_cnt", {5'd0, u_dut.cnt}, 32'd10);
    sys_rst_n = 1'b0;
    cycle();
    sys_rst_n = 1'b1;
    repeat (60) cycle();
    chk("queue_empty", q_a.size() + q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
